led_switch_io: RTL and testbench

//  Peripheral-side responder for the CPU's memory/IO decode. Holds the 24 board

---
 rtl/led_switch_io.sv | 131 +++++++++++++
 tb/tb_led_switch_io.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_switch_io.sv
// LED output registers and debounced switch input port for the CPU IO decode.
// LEDs are written as a low halfword and a high byte; switches are synchronised, debounced and read back.
module led_switch_io #(
    parameter int          DEBOUNCE_CYCLES = 20,
    parameter int          CNT_W           = 16,
    parameter logic [23:0] LED_RESET       = 24'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ledctrl,
    input  logic        switchctrl,
    input  logic        ioread,
    input  logic        iowrite,
    input  logic [1:0]  address,
    input  logic [15:0] write_data,
    output logic [15:0] ioread_data,
    input  logic [23:0] switch_in,
    output logic [23:0] led_out,
    output logic        dbg_state
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [23:0]      r_led;
    logic [23:0]      r_sw_s1;
    logic [23:0]      r_sw_s2;
    logic [23:0]      r_cand;
    logic [23:0]      r_committed;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;

    state_t           w_state_nxt;
    logic [23:0]      w_cand_nxt;
    logic [23:0]      w_committed_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_rd_sel;

    // LED registers: only iowrite-qualified selects at the two aligned addresses update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_led <= LED_RESET;
        end else if (iowrite && ledctrl) begin
            if (address == 2'b00) begin
                r_led[15:0] <= write_data;
            end else if (address == 2'b10) begin
                r_led[23:16] <= write_data[7:0];
            end
        end
    end

    assign led_out = r_led;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sw_s1     <= 24'h0;
            r_sw_s2     <= 24'h0;
            r_cand      <= 24'h0;
            r_committed <= 24'h0;
            r_cnt       <= '0;
            r_state     <= ST_STABLE;
        end else begin
            r_sw_s1     <= switch_in;
            r_sw_s2     <= r_sw_s1;
            r_cand      <= w_cand_nxt;
            r_committed <= w_committed_nxt;
            r_cnt       <= w_cnt_nxt;
            r_state     <= w_state_nxt;
        end
    end

    // A return to the committed value abandons settling; any other change restarts the count
    always_comb begin
        w_state_nxt     = r_state;
        w_cand_nxt      = r_cand;
        w_committed_nxt = r_committed;
        w_cnt_nxt       = r_cnt;
        case (r_state)
            ST_STABLE: begin
                if (r_sw_s2 != r_committed) begin
                    w_state_nxt = ST_SETTLING;
                    w_cand_nxt  = r_sw_s2;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            ST_SETTLING: begin
                if (r_sw_s2 == r_committed) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_sw_s2 != r_cand) begin
                    w_cand_nxt = r_sw_s2;
                    w_cnt_nxt  = CNT_ONE;
                end else if (r_cnt >= CNT_LAST) begin
                    w_committed_nxt = r_cand;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = ST_STABLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign dbg_state = r_state;

    // Combinational read so the single-cycle datapath sees the pre-edge committed value
    assign w_rd_sel = ioread && switchctrl && !reset;

    always_comb begin
        ioread_data = 16'h0000;
        if (w_rd_sel) begin
            if (address == 2'b00) begin
                ioread_data = r_committed[15:0];
            end else if (address == 2'b10) begin
                ioread_data = {8'h00, r_committed[23:16]};
            end
        end
    end

endmodule

// File: tb/tb_led_switch_io.sv
// Randomised bench for led_switch_io with a run-length switch model and a queue-based scoreboard.
module tb_led_switch_io;

    localparam int DEB = 20;

    logic        clock;
    logic        reset;
    logic        ledctrl;
    logic        switchctrl;
    logic        ioread;
    logic        iowrite;
    logic [1:0]  address;
    logic [15:0] write_data;
    logic [15:0] ioread_data;
    logic [23:0] switch_in;
    logic [23:0] led_out;
    logic        dbg_state;

    int check_cnt = 0;
    int fail_cnt  = 0;

    logic [39:0] exp_q[$];

    // model state
    logic [23:0] m_led;
    logic [23:0] m_comm;
    logic [23:0] m_s1;
    logic [23:0] m_s2;
    logic [23:0] run_val;
    int          run_len;

    led_switch_io #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(16),
        .LED_RESET(24'h0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ledctrl(ledctrl),
        .switchctrl(switchctrl),
        .ioread(ioread),
        .iowrite(iowrite),
        .address(address),
        .write_data(write_data),
        .ioread_data(ioread_data),
        .switch_in(switch_in),
        .led_out(led_out),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic model_reset();
        m_led   = 24'h0;
        m_comm  = 24'h0;
        m_s1    = 24'h0;
        m_s2    = 24'h0;
        run_val = 24'h0;
        run_len = 0;
    endtask

    // Committed value follows the synchronised input once it has been the same
    // non-committed value for DEB consecutive clock samples.
    task automatic model_edge();
        logic [23:0] s;
        if (iowrite && ledctrl) begin
            if (address == 2'b00) m_led[15:0] = write_data;
            else if (address == 2'b10) m_led[23:16] = write_data[7:0];
        end
        s = m_s2;
        if (s == run_val) run_len = run_len + 1;
        else begin
            run_val = s;
            run_len = 1;
        end
        if (run_val != m_comm && run_len >= DEB) m_comm = run_val;
        m_s2 = m_s1;
        m_s1 = switch_in;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_reset();
            else model_edge();
        end
    end

    // expected-response producer: runs after the driver has settled the cycle's inputs
    initial begin
        logic [15:0] e_rd;
        forever begin
            @(negedge clock);
            #1;
            e_rd = 16'h0000;
            if (!reset && ioread && switchctrl) begin
                if (address == 2'b00) e_rd = m_comm[15:0];
                else if (address == 2'b10) e_rd = {8'h00, m_comm[23:16]};
            end
            exp_q.push_back({e_rd, m_led});
        end
    end

    // monitor
    initial begin
        logic [39:0] e;
        forever begin
            @(negedge clock);
            #3;
            check_cnt = check_cnt + 1;
            if (exp_q.size() == 0) begin
                fail_cnt = fail_cnt + 1;
                $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
            end else begin
                e = exp_q.pop_front();
                if (ioread_data !== e[39:24]) begin
                    fail_cnt = fail_cnt + 1;
                    $display("FAIL ioread_data at %0t: got %h expected %h (ioread=%b sel=%b addr=%0d)",
                             $time, ioread_data, e[39:24], ioread, switchctrl, address);
                end
                check_cnt = check_cnt + 1;
                if (led_out !== e[23:0]) begin
                    fail_cnt = fail_cnt + 1;
                    $display("FAIL led_out at %0t: got %h expected %h", $time, led_out, e[23:0]);
                end
            end
        end
    end

    // driver: one clock of stimulus, read side always randomised
    task automatic step(input logic rst, input logic [23:0] sw, input logic do_wr,
                        input logic [1:0] wa, input logic [15:0] wd);
        @(negedge clock);
        reset      = rst;
        switch_in  = sw;
        ioread     = ($urandom_range(0, 3) != 0);
        switchctrl = ($urandom_range(0, 3) != 0);
        if (do_wr) begin
            iowrite    = 1'b1;
            ledctrl    = 1'b1;
            address    = wa;
            write_data = wd;
        end else begin
            iowrite    = 1'b0;
            ledctrl    = $urandom_range(0, 1) != 0;
            address    = 2'($urandom_range(0, 3));
            write_data = 16'($urandom);
        end
    endtask

    task automatic idle(input int n, input logic [23:0] sw);
        for (int i = 0; i < n; i++) step(1'b0, sw, 1'b0, 2'b00, 16'h0);
    endtask

    initial begin
        logic [23:0] sw;
        reset      = 1'b1;
        switch_in  = 24'hFFFFFF;
        ledctrl    = 1'b0;
        switchctrl = 1'b0;
        ioread     = 1'b0;
        iowrite    = 1'b0;
        address    = 2'b00;
        write_data = 16'h0;

        // reset with all switches on, then let them commit
        for (int i = 0; i < 3; i++) step(1'b1, 24'hFFFFFF, 1'b0, 2'b00, 16'h0);
        idle(30, 24'hFFFFFF);

        // LED writes, including unaligned addresses that must not update
        step(1'b0, 24'hFFFFFF, 1'b1, 2'b00, 16'hA5C3);
        step(1'b0, 24'hFFFFFF, 1'b1, 2'b10, 16'h007E);
        step(1'b0, 24'hFFFFFF, 1'b1, 2'b01, 16'h1234);
        step(1'b0, 24'hFFFFFF, 1'b1, 2'b11, 16'h5678);
        idle(5, 24'hFFFFFF);

        // clean change
        idle(30, 24'h000000);
        idle(30, 24'h00F00F);

        // bounce on bit0
        idle(30, 24'h000000);
        for (int i = 0; i < 60; i++) step(1'b0, ((i / 5) % 2 == 0) ? 24'h1 : 24'h0, 1'b0, 2'b00, 16'h0);
        idle(30, 24'h000001);

        // short glitch that returns to the committed value
        idle(30, 24'h000000);
        idle(10, 24'h000001);
        idle(25, 24'h000000);

        // reset while settling
        idle(12, 24'h123456);
        step(1'b1, 24'h123456, 1'b0, 2'b00, 16'h0);
        step(1'b1, 24'h123456, 1'b0, 2'b00, 16'h0);
        idle(30, 24'h123456);

        // random mix
        sw = 24'h123456;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) sw = 24'($urandom);
            else if ($urandom_range(0, 39) == 0) sw = sw ^ (24'h1 << $urandom_range(0, 23));
            if ($urandom_range(0, 3) == 0)
                step(1'b0, sw, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom));
            else
                step(1'b0, sw, 1'b0, 2'b00, 16'h0);
        end
        idle(30, sw);

        @(negedge clock);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fail_cnt = fail_cnt + 1;
        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $fatal(1, "watchdog");
    end

endmodule
